// File: rtl/nios2_debug_scan_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG debug scan host.
// Contents:
//   DR_W_DEF / IR_W_DEF    default DR and virtual IR widths
//   IR_*                   virtual IR opcodes understood by the CPU debug slave
//   scan_state_e           scan sequencer state encoding
package nios2_debug_scan_pkg;

  localparam int unsigned DR_W_DEF = 38;
  localparam int unsigned IR_W_DEF = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACE     = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr,
    StRti,
    StDone
  } scan_state_e;

endpackage

// File: rtl/nios2_debug_tck_gen.sv
// TCK generator for the debug scan host.
// Counts clk cycles while run_i is high and toggles TCK every TCK_DIV cycles.
// rise_o / fall_o flag the clk edge on which the registered TCK goes 0->1 / 1->0.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   run_i    scan in progress; when low TCK is forced to 0 and the divider cleared
//   tck_o    generated TCK (registered)
//   rise_o   this clk edge makes TCK rise
//   fall_o   this clk edge makes TCK fall
module nios2_debug_tck_gen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            tck_q;
  logic            wrap;

  assign wrap   = run_i && (cnt_q == CntW'(TCK_DIV - 1));
  assign rise_o = wrap && !tck_q;
  assign fall_o = wrap && tck_q;
  assign tck_o  = tck_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || !run_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/nios2_debug_scan_host.sv
// Initiator end of the Nios II virtual-JTAG debug link.
// Accepts one command (virtual IR + DR word), plays the UIR, CDR, SDR x DR_W, UDR, RTI
// sequence on the vji_* pins with a divided TCK, and returns the captured TDO word.
// Each virtual state lasts exactly one TCK period: it starts at a TCK fall (or at accept
// for the first one), TCK rises mid-period and the state ends at the next fall.
// Optional feature: define DBG_SCAN_IR_CACHE_EN to skip UIR when the IR matches the last
// one sent; rsp_ir then reports the IR status captured by that earlier UIR.
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake; cmd_ir_i/cmd_dr_i latched on accept
//   rsp_valid_o/rsp_ready_i   response handshake; rsp_dr_o/rsp_ir_o held while valid
//   vji_tck_o, vji_tdi_o      TCK and serial data to the debug slave
//   vji_tdo_i, vji_ir_out_i   serial data and IR status from the debug slave
//   vji_ir_in_o               IR presented to the slave
//   vji_uir/cdr/sdr/udr/rti_o virtual-state strobes (one-hot while scanning)
module nios2_debug_scan_host
  import nios2_debug_scan_pkg::*;
#(
  parameter int unsigned DR_W    = DR_W_DEF,
  parameter int unsigned IR_W    = IR_W_DEF,
  parameter int unsigned TCK_DIV = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [IR_W-1:0] cmd_ir_i,
  input  logic [DR_W-1:0] cmd_dr_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DR_W-1:0] rsp_dr_o,
  output logic [IR_W-1:0] rsp_ir_o,
  output logic            vji_tck_o,
  output logic            vji_tdi_o,
  input  logic            vji_tdo_i,
  output logic [IR_W-1:0] vji_ir_in_o,
  input  logic [IR_W-1:0] vji_ir_out_i,
  output logic            vji_uir_o,
  output logic            vji_cdr_o,
  output logic            vji_sdr_o,
  output logic            vji_udr_o,
  output logic            vji_rti_o
);

  localparam int unsigned BitW = (DR_W > 1) ? $clog2(DR_W) : 1;

  scan_state_e     state_q;
  logic [DR_W-1:0] dr_q;
  logic [DR_W-1:0] rsp_dr_q;
  logic [IR_W-1:0] rsp_ir_q;
  logic [IR_W-1:0] ir_in_q;
  logic [BitW-1:0] bit_cnt_q;
  logic            rsp_valid_q;
  logic            tdi_q;
  logic            uir_q, cdr_q, sdr_q, udr_q, rti_q;

  logic tck_run, tck_rise, tck_fall;
  logic accept;
  logic cache_hit;

  assign tck_run = (state_q != StIdle) && (state_q != StDone);

  nios2_debug_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .run_i   (tck_run),
    .tck_o   (vji_tck_o),
    .rise_o  (tck_rise),
    .fall_o  (tck_fall)
  );

  // A response being consumed this clk frees the host for a new command in the same clk.
  assign cmd_ready_o = (state_q == StIdle) && (!rsp_valid_q || rsp_ready_i);
  assign accept      = cmd_valid_i && cmd_ready_o;

`ifdef DBG_SCAN_IR_CACHE_EN
  // ir_in_q always holds the IR most recently sent; the flag says whether it is meaningful.
  logic ir_cache_vld_q;

  assign cache_hit = ir_cache_vld_q && (cmd_ir_i == ir_in_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ir_cache_vld_q <= 1'b0;
    end else if (accept) begin
      ir_cache_vld_q <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      dr_q        <= '0;
      rsp_dr_q    <= '0;
      rsp_ir_q    <= '0;
      ir_in_q     <= '0;
      bit_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            ir_in_q <= cmd_ir_i;
            dr_q    <= cmd_dr_i;
            if (cache_hit) begin
              state_q <= StCdr;
              cdr_q   <= 1'b1;
            end else begin
              state_q <= StUir;
              uir_q   <= 1'b1;
            end
          end
        end
        StUir: begin
          if (tck_rise) begin
            rsp_ir_q <= vji_ir_out_i;
          end
          if (tck_fall) begin
            uir_q   <= 1'b0;
            cdr_q   <= 1'b1;
            state_q <= StCdr;
          end
        end
        StCdr: begin
          if (tck_fall) begin
            cdr_q     <= 1'b0;
            sdr_q     <= 1'b1;
            tdi_q     <= dr_q[0];
            dr_q      <= {1'b0, dr_q[DR_W-1:1]};
            bit_cnt_q <= '0;
            state_q   <= StSdr;
          end
        end
        StSdr: begin
          // Samples enter at the MSB so the first one ends up in bit 0.
          if (tck_rise) begin
            rsp_dr_q <= {vji_tdo_i, rsp_dr_q[DR_W-1:1]};
          end
          if (tck_fall) begin
            if (bit_cnt_q == BitW'(DR_W - 1)) begin
              sdr_q   <= 1'b0;
              udr_q   <= 1'b1;
              state_q <= StUdr;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
              tdi_q     <= dr_q[0];
              dr_q      <= {1'b0, dr_q[DR_W-1:1]};
            end
          end
        end
        StUdr: begin
          if (tck_fall) begin
            udr_q   <= 1'b0;
            rti_q   <= 1'b1;
            tdi_q   <= 1'b0;
            state_q <= StRti;
          end
        end
        StRti: begin
          if (tck_fall) begin
            rti_q   <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          rsp_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dr_o    = rsp_dr_q;
  assign rsp_ir_o    = rsp_ir_q;
  assign vji_tdi_o   = tdi_q;
  assign vji_ir_in_o = ir_in_q;
  assign vji_uir_o   = uir_q;
  assign vji_cdr_o   = cdr_q;
  assign vji_sdr_o   = sdr_q;
  assign vji_udr_o   = udr_q;
  assign vji_rti_o   = rti_q;

endmodule

// File: tb/tb_nios2_debug_scan_host.sv
// Bench for nios2_debug_scan_host: directed and random commands against a reference
// model of the scan protocol (expected strobe order, latency, captured word, IR status).
module tb_nios2_debug_scan_host;

  localparam int DrW = 38;
  localparam int IrW = 2;
  localparam int Div = 2;
`ifdef DBG_SCAN_IR_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IrW-1:0] cmd_ir = '0;
  logic [DrW-1:0] cmd_dr = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DrW-1:0] rsp_dr;
  logic [IrW-1:0] rsp_ir;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [IrW-1:0] vji_ir_in;
  logic [IrW-1:0] ir_out_val = '0;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  // 0: loopback, 1: inverted loopback, 2: constant 0, 3: constant 1
  int tdo_mode = 0;
  assign vji_tdo = (tdo_mode == 0) ? vji_tdi :
                   (tdo_mode == 1) ? ~vji_tdi : (tdo_mode == 3);

  int n_checks = 0;
  int n_errs   = 0;

  // Model of the optional IR cache.
  bit             cache_vld = 1'b0;
  logic [IrW-1:0] cache_ir = '0;
  logic [IrW-1:0] cache_rsp_ir = '0;

  always #5 clk = ~clk;

  nios2_debug_scan_host #(
    .DR_W    (DrW),
    .IR_W    (IrW),
    .TCK_DIV (Div)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_ir_i     (cmd_ir),
    .cmd_dr_i     (cmd_dr),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dr_o     (rsp_dr),
    .rsp_ir_o     (rsp_ir),
    .vji_tck_o    (vji_tck),
    .vji_tdi_o    (vji_tdi),
    .vji_tdo_i    (vji_tdo),
    .vji_ir_in_o  (vji_ir_in),
    .vji_ir_out_i (ir_out_val),
    .vji_uir_o    (vji_uir),
    .vji_cdr_o    (vji_cdr),
    .vji_sdr_o    (vji_sdr),
    .vji_udr_o    (vji_udr),
    .vji_rti_o    (vji_rti)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int strobe_code();
    if (vji_uir) return 1;
    if (vji_cdr) return 2;
    if (vji_sdr) return 3;
    if (vji_udr) return 4;
    if (vji_rti) return 5;
    return 0;
  endfunction

  function automatic int strobe_cnt();
    return int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_rti);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tck"}, vji_tck, 0);
    check_eq({tag, "_strobes"}, strobe_cnt(), 0);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_dr"}, rsp_dr, 0);
    check_eq({tag, "_rsp_ir"}, rsp_ir, 0);
    check_eq({tag, "_tdi"}, vji_tdi, 0);
    check_eq({tag, "_ir_in"}, vji_ir_in, 0);
  endtask

  // abort_at > 0: assert reset right after that SDR rise and check the abort.
  task automatic run_cmd(input logic [IrW-1:0] ir, input logic [DrW-1:0] dr, input int mode,
                         input logic [IrW-1:0] irout, input int hold, input int abort_at);
    int             seq[$];
    int             exp_seq[$];
    bit             hit;
    bit             done;
    bit             prev_tck;
    int             lat, sdr_rises, multi, nmis, code, bad;
    logic [DrW-1:0] exp_dr;
    logic [IrW-1:0] exp_ir;
    logic [63:0]    r64;

    hit        = CacheEn && cache_vld && (ir == cache_ir);
    tdo_mode   = mode;
    ir_out_val = irout;
    @(negedge clk);
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_dr    = dr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    r64       = {$urandom, $urandom};
    cmd_dr    = r64[DrW-1:0];
    cmd_ir    = IrW'($urandom);
    cache_vld = 1'b1;
    cache_ir  = ir;

    done = 1'b0; prev_tck = 1'b0; lat = 0; sdr_rises = 0; multi = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (strobe_cnt() > 1 || (strobe_cnt() == 0 && vji_tck)) multi++;
      if (!prev_tck && vji_tck) begin
        code = strobe_code();
        seq.push_back(code);
        if (code == 3) begin
          sdr_rises++;
          if (abort_at != 0 && sdr_rises == abort_at) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            check_reset_outputs("abort");
            reset     = 1'b0;
            cache_vld = 1'b0;
            bad = 0;
            for (int i = 0; i < 30; i++) begin
              @(negedge clk);
              if (rsp_valid || vji_tck || strobe_cnt() != 0) bad++;
            end
            check_eq("abort_quiet", bad, 0);
            return;
          end
        end
      end
      prev_tck = vji_tck;
      if (rsp_valid) done = 1'b1;
    end
    check_eq("rsp_timeout", done, 1);
    if (!done) return;

    case (mode)
      0:       exp_dr = dr;
      1:       exp_dr = ~dr;
      2:       exp_dr = '0;
      default: exp_dr = '1;
    endcase
    exp_ir       = hit ? cache_rsp_ir : irout;
    cache_rsp_ir = exp_ir;
    if (!hit) exp_seq.push_back(1);
    exp_seq.push_back(2);
    for (int i = 0; i < DrW; i++) exp_seq.push_back(3);
    exp_seq.push_back(4);
    exp_seq.push_back(5);

    check_eq("latency", lat, (DrW + 4 - int'(hit)) * 2 * Div + 1);
    check_eq("rsp_dr", rsp_dr, exp_dr);
    check_eq("rsp_ir", rsp_ir, exp_ir);
    check_eq("ir_in", vji_ir_in, ir);
    check_eq("seq_len", seq.size(), exp_seq.size());
    nmis = 0;
    for (int i = 0; i < seq.size() && i < exp_seq.size(); i++)
      if (seq[i] != exp_seq[i]) nmis++;
    check_eq("seq_order", nmis, 0);
    check_eq("onehot", multi, 0);
    check_eq("done_quiet", strobe_cnt() + int'(vji_tck), 0);

    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || vji_tck || rsp_dr !== exp_dr || rsp_ir !== exp_ir) bad++;
    end
    if (hold > 0) check_eq("hold", bad, 0);

    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_cleared", rsp_valid, 0);
    check_eq("ready_again", cmd_ready, 1);
  endtask

  initial begin
    logic [63:0] r64;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_idle");

    run_cmd(2'b00, 38'h2A_5A5A_5A5A, 0, 2'b01, 0, 0);
    run_cmd(2'b11, 38'h15_0F0F_1234, 3, 2'b10, 50, 0);

    for (int n = 0; n < 6; n++) begin
      r64 = {$urandom, $urandom};
      run_cmd(IrW'($urandom), r64[DrW-1:0], int'($urandom_range(0, 3)),
              IrW'($urandom), int'($urandom_range(0, 5)), 0);
    end

    r64 = {$urandom, $urandom};
    run_cmd(2'b10, r64[DrW-1:0], 0, 2'b11, 0, 17);
    r64 = {$urandom, $urandom};
    run_cmd(2'b10, r64[DrW-1:0], 0, 2'b01, 0, 0);

    run_cmd(2'b01, 38'h01_2345_6789, 1, 2'b10, 0, 0);
    run_cmd(2'b01, 38'h3E_DCBA_9876, 0, 2'b00, 0, 0);
    run_cmd(2'b11, 38'h00_FFFF_0000, 0, 2'b11, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
